data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the data cache's refill/store path. It accepts single-word read and write requests over a valid/ready request channel, models a fixed backing-store access latency with a countdown FSM, commits byte-enabled writes into a word-addressed array, and returns read data or a write acknowledge over a valid/ready response channel. Performance counters expose accepted requests and request-side stall cycles, for correlation with the cache's hit/miss counters.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; fixed at 32, so there are 4 byte lanes
- MEM_WORDS, 1024, array depth in words; must be a power of two
- LATENCY, 4, wait cycles from acceptance to response; must be ≥1, elaboration error if 0
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address; word index = req_addr[ADDR_WIDTH-1:2]; bits [1:0] ignored
- req_wdata  in  DATA_WIDTH  write data, lane-aligned
- req_be  in  4  byte enables for writes; ignored for reads
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  DATA_WIDTH  read data; for a write, the merged word after the write
- resp_err  out  1  out-of-range access
- req_count  out  32  number of accepted requests
- stall_count  out  32  cycles with req_valid=1 and req_ready=0

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: capture we, addr, wdata and be; load cnt=LATENCY-1; go to WAIT; req_count+1.
- **WAIT**
  - req_ready=0.
  - If cnt≠0: decrement cnt.
  - If cnt=0: perform the access on that edge and go to RESP.
    - Read: resp_rdata ← mem[idx].
    - Write: lanes with be[i]=1 are replaced by wdata lanes; resp_rdata ← the merged word.
- **RESP**
  - resp_valid=1; request side stays blocked.
  - On resp_ready: go to IDLE and drop resp_valid.
  - resp_rdata and resp_err stay stable while resp_valid=1 and resp_ready=0.
- **Error:** if idx ≥ MEM_WORDS, there is no array access, no write is committed, resp_err=1 and resp_rdata=0.
- **Write with be=0:** no lanes change; the response carries the unchanged word.
- **Counters:** both wrap modulo 2^32; stall_count increments in WAIT and RESP whenever req_valid=1.
- **Reset (asynchronous):** rst_n low forces IDLE, cnt=0 and clears the captured request. Output values are listed under Timing.
- **Reset mid-operation:** a request in WAIT is abandoned and its write is not committed. Array contents are not reset.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, req_count=0, stall_count=0.
- **Latency:** resp_valid rises on the LATENCY-th rising edge after the accepting edge, i.e. LATENCY cycles are spent in WAIT.
- **Response handshake:** completes on an edge where resp_valid and resp_ready are both 1. req_ready returns to 1 in the following cycle.
- **Throughput:** with resp_ready held at 1, one request per LATENCY+2 cycles. A request is never accepted in the same cycle as a response handshake.
- **Write visibility:** a read accepted after a write's response returns the written data.
- resp_ready asserted before resp_valid has no effect.

## Structure
- Package data_mem_resp_pkg:
  - resp_state_e enum {IDLE, WAIT, RESP};
  - NUM_LANES=4 constant;
  - a function that merges wdata into a word under be.
- Sub-module data_mem_array: single-port word array with synchronous byte-enabled write and combinational read, MEM_WORDS deep. The FSM, counters and response registers stay in data_mem_responder.

## Test plan
- **Reset:** assert rst_n=0 mid-WAIT of a write to 0x10 → outputs at reset values. A later read of 0x10 returns the pre-write contents.
- **Write then read:**
  - write 0x20, wdata=0xDEADBEEF, be=4'hF, LATENCY=4 → resp_valid on the 4th edge after acceptance with rdata=0xDEADBEEF;
  - read 0x20 → 0xDEADBEEF, resp_err=0.
- **Byte enables:** word 0x20=0xDEADBEEF; write wdata=0x11223344, be=4'b0101 → rdata=0xDE22BE44; be=0 → 0xDE22BE44 unchanged.
- **Backpressure:**
  - hold resp_ready=0 for 5 cycles with req_valid=1 → resp_valid/rdata stable and req_ready=0 throughout;
  - stall_count grows by LATENCY+5;
  - resp_ready=1 → IDLE next cycle.
- **Range error:** MEM_WORDS=1024, read 0x1000 → resp_err=1, rdata=0. Write 0x1000 → no array change (aliased word 0x0 unchanged).
- **Throughput/counters:** 8 back-to-back reads with resp_ready=1 → 8 responses spaced LATENCY+2 cycles apart, req_count=8.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and the byte-lane merge helper for the data-cache memory responder.
package data_mem_resp_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int WORD_W    = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    function automatic logic [WORD_W-1:0] merge_be(
        input logic [WORD_W-1:0]    old_word,
        input logic [WORD_W-1:0]    wdata,
        input logic [NUM_LANES-1:0] be
    );
        logic [WORD_W-1:0] m;
        m = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) m[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
        end
        return m;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the data cache (master) and the memory responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import data_mem_resp_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NUM_LANES-1:0]  req_be;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port word array: combinational read, synchronous byte-enabled write, no reset.
module data_mem_array
    import data_mem_resp_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [IDX_W-1:0]                  idx,
    input  logic [NUM_LANES-1:0]              be,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]  wdata,
    output logic [NUM_LANES-1:0][LANE_W-1:0]  rdata
);

    logic [NUM_LANES-1:0][LANE_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (be[l]) mem[idx][l] <= wdata[l];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder: accept, count down LATENCY cycles, access the array, respond.
module data_mem_responder
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus,
    output logic [31:0]           req_count,
    output logic [31:0]           stall_count
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int WIDX_W = ADDR_WIDTH - 2;
    // Counter only ever holds LATENCY-1 down to 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be >= 1");
    end
    if ((1 << IDX_W) != MEM_WORDS) begin : g_bad_depth
        $error("data_mem_responder: MEM_WORDS must be a power of two");
    end
    if (DATA_WIDTH != WORD_W) begin : g_bad_width
        $error("data_mem_responder: DATA_WIDTH must be 32");
    end
    if (WIDX_W <= IDX_W) begin : g_bad_addr
        $error("data_mem_responder: ADDR_WIDTH too narrow for MEM_WORDS");
    end

    resp_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic accept, access;

    logic                  cap_we;
    logic [WIDX_W-1:0]     cap_widx;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [NUM_LANES-1:0]  cap_be;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  in_range;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] merged;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Any set bit above the array index means the word lies beyond MEM_WORDS.
    assign in_range = ~|cap_widx[WIDX_W-1:IDX_W];
    assign mem_we   = access && cap_we && in_range;
    assign merged   = merge_be(mem_rdata, cap_wdata, cap_be);

    data_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (cap_widx[IDX_W-1:0]),
        .be    (cap_be),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_we    <= 1'b0;
            cap_widx  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else if (accept) begin
            cap_we    <= bus.req_we;
            cap_widx  <= bus.req_addr[ADDR_WIDTH-1:2];
            cap_wdata <= bus.req_wdata;
            cap_be    <= bus.req_be;
        end
    end

    // Response registers only change on the access edge, so they hold through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access) begin
            err_q <= !in_range;
            if (!in_range)   rdata_q <= '0;
            else if (cap_we) rdata_q <= merged;
            else             rdata_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_count   <= '0;
            stall_count <= '0;
        end else begin
            req_count   <= req_count + 32'(accept);
            stall_count <= stall_count + 32'(bus.req_valid && (state != IDLE));
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: reset, write/read, byte enables, backpressure, range, throughput.
module tb_data_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_count, stall_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int resp_cyc = 0;

    data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

    data_mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_WORDS  (1024),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bif.slave),
        .req_count   (req_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request with resp_ready held high; returns after the handshake edge (+1).
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat, output logic idle_after);
        int n;
        bif.req_valid  = 1'b1;
        bif.req_we     = we;
        bif.req_addr   = addr;
        bif.req_wdata  = wdata;
        bif.req_be     = be;
        bif.resp_ready = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        n = 0;
        while (!bif.resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        lat      = n;
        resp_cyc = cyc;
        rdata    = bif.resp_rdata;
        err      = bif.resp_err;
        @(posedge clk); #1;
        idle_after = bif.req_ready && !bif.resp_valid;
    endtask

    initial begin
        logic [31:0] rd, rd0;
        logic        er, idl;
        int          lat, prev, s0;

        bif.req_valid  = 1'b0;
        bif.req_we     = 1'b0;
        bif.req_addr   = '0;
        bif.req_wdata  = '0;
        bif.req_be     = '0;
        bif.resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(bif.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
        check("rst_rdata",      bif.resp_rdata, 32'd0);
        check("rst_err",        32'(bif.resp_err), 32'd0);
        check("rst_req_count",  req_count, 32'd0);
        check("rst_stall",      stall_count, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known content at 0x10, then abandon a write to it by resetting mid-WAIT.
        do_req(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er, lat, idl);
        check("w10_rdata", rd, 32'hCAFEF00D);
        bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_addr = 32'h10;
        bif.req_wdata = 32'h0BADBEEF; bif.req_be = 4'hF; bif.resp_ready = 1'b0;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready",  32'(bif.req_ready), 32'd1);
        check("midrst_resp_valid", 32'(bif.resp_valid), 32'd0);
        check("midrst_rdata",      bif.resp_rdata, 32'd0);
        check("midrst_err",        32'(bif.resp_err), 32'd0);
        check("midrst_req_count",  req_count, 32'd0);
        check("midrst_stall",      stall_count, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, idl);
        check("r10_after_rst", rd, 32'hCAFEF00D);

        // Full write, latency, read-back.
        do_req(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, rd, er, lat, idl);
        check("w20_latency", 32'(lat), 32'(LAT));
        check("w20_rdata",   rd, 32'hDEADBEEF);
        check("w20_idle",    32'(idl), 32'd1);
        do_req(1'b0, 32'h23, 32'h0, 4'h0, rd, er, lat, idl);
        check("r20_rdata", rd, 32'hDEADBEEF);
        check("r20_err",   32'(er), 32'd0);

        // Byte enables.
        do_req(1'b1, 32'h20, 32'h11223344, 4'b0101, rd, er, lat, idl);
        check("be5_rdata", rd, 32'hDE22BE44);
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, idl);
        check("be0_rdata", rd, 32'hDE22BE44);
        do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, idl);
        check("be_readback", rd, 32'hDE22BE44);

        // Backpressure: resp_ready low for 5 RESP cycles with req_valid held.
        s0 = int'(stall_count);
        bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_addr = 32'h20; bif.resp_ready = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (!bif.resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(LAT));
        rd0 = bif.resp_rdata;
        check("bp_rdata", rd0, 32'hDE22BE44);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", 32'(bif.resp_valid), 32'd1);
            check("bp_rdata_hold", bif.resp_rdata, 32'hDE22BE44);
            check("bp_req_ready",  32'(bif.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bif.req_valid  = 1'b0;
        bif.resp_ready = 1'b1;
        check("bp_stall_delta", stall_count - 32'(s0), 32'(LAT + 5));
        @(posedge clk); #1;
        check("bp_release_valid", 32'(bif.resp_valid), 32'd0);
        check("bp_release_ready", 32'(bif.req_ready), 32'd1);

        // Range: top in-range word, out-of-range read/write, aliased word 0 intact.
        do_req(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, rd, er, lat, idl);
        do_req(1'b1, 32'hFFC, 32'h12345678, 4'hF, rd, er, lat, idl);
        check("top_word_err",   32'(er), 32'd0);
        check("top_word_rdata", rd, 32'h12345678);
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat, idl);
        check("oor_rd_err",   32'(er), 32'd1);
        check("oor_rd_rdata", rd, 32'd0);
        do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat, idl);
        check("oor_wr_err",   32'(er), 32'd1);
        check("oor_wr_rdata", rd, 32'd0);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, idl);
        check("alias0_rdata", rd, 32'h5A5A5A5A);
        check("alias0_err",   32'(er), 32'd0);

        // Throughput from a fresh reset: 8 back-to-back reads.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, idl);
            if (i == 0) check("tp_rdata", rd, 32'hDE22BE44);
            else        check("tp_spacing", 32'(resp_cyc - prev), 32'(LAT + 2));
            prev = resp_cyc;
        end
        check("tp_req_count", req_count, 32'd8);
        check("tp_stall",     stall_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
